// File: rtl/skid_hold_buffer_pkg.sv
// rtl/skid_hold_buffer_pkg.sv - shared state encoding for the skid hold buffer
package skid_hold_buffer_pkg;

   // Occupancy states; 2'b11 is unused and recovers to ST_EMPTY
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_t;

   localparam logic READY_ON_RESET = 1'b1;

endpackage

// File: rtl/skid_hold_buffer.sv
// rtl/skid_hold_buffer.sv - two-entry registered valid/ready hold stage
module skid_hold_buffer
   import skid_hold_buffer_pkg::*;
#(
   parameter int n = 8
) (
   input  logic         clk_in,
   input  logic         rst_n_in,
   input  logic [n-1:0] d_in,
   input  logic         valid_in,
   output logic         ready_out,
   output logic [n-1:0] d_out,
   output logic         valid_out,
   input  logic         ready_in
);

   skid_state_t  state_q, state_d;
   logic [n-1:0] main_q, main_d;
   logic [n-1:0] skid_q, skid_d;
   logic         valid_q, valid_d;
   logic         ready_q, ready_d;
   logic         xfer_in, xfer_out;

   // Handshakes are judged from registered outputs, so ready_out never sees ready_in
   assign xfer_in  = valid_in & ready_q;
   assign xfer_out = valid_q & ready_in;

   // Next-state and next-data selection; every target defaults to hold
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      valid_d = valid_q;
      ready_d = ready_q;
      case (state_q)
         ST_EMPTY: begin
            valid_d = 1'b0;
            ready_d = 1'b1;
            if (xfer_in) begin
               main_d  = d_in;
               valid_d = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (xfer_in && xfer_out) begin
               main_d = d_in;
            end else if (xfer_in) begin
               skid_d  = d_in;
               ready_d = 1'b0;
               state_d = ST_FULL;
            end else if (xfer_out) begin
               valid_d = 1'b0;
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // Producer is blocked here; the skid word moves up once the consumer takes main
            if (xfer_out) begin
               main_d  = skid_q;
               ready_d = 1'b1;
               state_d = ST_BUSY;
            end
         end
         default: begin
            valid_d = 1'b0;
            ready_d = 1'b1;
            state_d = ST_EMPTY;
         end
      endcase
   end

   // State and handshake flags
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= ST_EMPTY;
         valid_q <= 1'b0;
         ready_q <= READY_ON_RESET;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
      end
   end

   // Data registers; main keeps its last word when the buffer goes empty
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

   assign d_out     = main_q;
   assign valid_out = valid_q;
   assign ready_out = ready_q;

endmodule

// File: tb/tb_skid_hold_buffer.sv
// tb/tb_skid_hold_buffer.sv - scoreboard bench for skid_hold_buffer
module tb_skid_hold_buffer;

   localparam int N = 8;

   logic         clk_in;
   logic         rst_n_in;
   logic [N-1:0] d_in;
   logic         valid_in;
   logic         ready_out;
   logic [N-1:0] d_out;
   logic         valid_out;
   logic         ready_in;

   int errors = 0;
   int checks = 0;

   // Reference: a FIFO holding at most two words, plus the last word delivered
   logic [N-1:0] model_q[$];
   logic [N-1:0] last_out = '0;

   skid_hold_buffer #(.n(N)) dut (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .d_in      (d_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .d_out     (d_out),
      .valid_out (valid_out),
      .ready_in  (ready_in)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: inputs and outputs are stable at the falling edge and decide the next rising edge
   always @(negedge clk_in) begin
      if (rst_n_in) begin
         check("valid_out", {31'd0, valid_out}, {31'd0, model_q.size() > 0});
         check("ready_out", {31'd0, ready_out}, {31'd0, model_q.size() < 2});
         if (valid_out && model_q.size() > 0)
            check("d_out", {24'd0, d_out}, {24'd0, model_q[0]});
         if (!valid_out)
            check("d_out_idle_hold", {24'd0, d_out}, {24'd0, last_out});
         if (valid_out && ready_in && model_q.size() > 0)
            last_out = model_q.pop_front();
         if (valid_in && ready_out)
            model_q.push_back(d_in);
      end
   end

   // Apply inputs for the next rising edge, then return just after it
   task automatic drive(input logic v, input logic [N-1:0] d, input logic r);
      valid_in = v;
      d_in     = d;
      ready_in = r;
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      logic         stalled;
      logic         rdy_prev;
      int           pv, pr;

      rst_n_in = 1'b1;
      valid_in = 1'b0;
      d_in     = '0;
      ready_in = 1'b0;
      #1 rst_n_in = 1'b0;
      #2;
      check("reset_valid", {31'd0, valid_out}, 32'd0);
      check("reset_ready", {31'd0, ready_out}, 32'd1);
      check("reset_d_out", {24'd0, d_out}, 32'd0);
      @(posedge clk_in);
      #1 rst_n_in = 1'b1;

      // Pass-through at full rate
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, N'(i), 1'b1);
         check("pass_d_out", {24'd0, d_out}, i);
         check("pass_ready", {31'd0, ready_out}, 32'd1);
      end
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b1);

      // Backpressure fills both entries
      drive(1'b1, 8'hA5, 1'b0);
      drive(1'b1, 8'h5A, 1'b0);
      check("bp_d_out", {24'd0, d_out}, 32'hA5);
      check("bp_ready", {31'd0, ready_out}, 32'd0);

      // Stalled producer is ignored while full
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'h3C, 1'b0);
         check("stall_d_out", {24'd0, d_out}, 32'hA5);
         check("stall_ready", {31'd0, ready_out}, 32'd0);
      end
      drive(1'b0, '0, 1'b1);
      check("bp_second", {24'd0, d_out}, 32'h5A);
      check("bp_ready_back", {31'd0, ready_out}, 32'd1);
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b1);

      // Drain a single word
      drive(1'b1, 8'h77, 1'b1);
      drive(1'b0, '0, 1'b1);
      check("drain_valid", {31'd0, valid_out}, 32'd0);
      check("drain_d_out", {24'd0, d_out}, 32'h77);

      // Random traffic; producer holds its word until accepted
      stalled = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         pv = (i < 5000) ? 50 : 85;
         pr = ((i / 500) % 2 == 0) ? 70 : 30;
         rdy_prev = ready_out;
         if (stalled)
            drive(valid_in, d_in, ($urandom_range(0, 99) < pr));
         else
            drive(($urandom_range(0, 99) < pv), N'($urandom), ($urandom_range(0, 99) < pr));
         stalled = valid_in && !rdy_prev;
      end
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b1);
      check("random_drained", model_q.size(), 32'd0);

      // Asynchronous reset while full discards both words
      drive(1'b1, 8'h11, 1'b0);
      drive(1'b1, 8'h22, 1'b0);
      check("pre_reset_full", {31'd0, ready_out}, 32'd0);
      #2 rst_n_in = 1'b0;
      model_q.delete();
      last_out = '0;
      #1;
      check("async_reset_valid", {31'd0, valid_out}, 32'd0);
      check("async_reset_ready", {31'd0, ready_out}, 32'd1);
      check("async_reset_d_out", {24'd0, d_out}, 32'd0);
      @(posedge clk_in);
      @(posedge clk_in);
      #1 rst_n_in = 1'b1;
      drive(1'b1, 8'h99, 1'b1);
      check("post_reset_accept", {24'd0, d_out}, 32'h99);
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b0);
      check("final_empty", model_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
